plate_ctrl: RTL and testbench

Controller that sequences the paddle (plate) datapath in the brick game. It converts player buttons, or an auto-tracking demo mode, into 4-bit plate control codes. Codes are issued at a fixed game-tick rate, with hold-to-accelerate and edge blocking. Its control output drives the plate block's control input, and it reads the plate's current position back as feedback.

---
 rtl/plate_pkg.sv | 43 ++++
 rtl/plate_tick_gen.sv | 34 +++
 rtl/plate_ctrl.sv | 183 ++++++++++++++++++
 tb/tb_plate_ctrl.sv | 363 ++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/plate_pkg.sv
// Shared definitions for the plate controller: control codes, plate width,
// FSM state encoding, request encoding and a lowest-set-bit helper.
package plate_pkg;

    localparam int PLATE_W = 16;

    localparam logic [3:0] CTRL_HOLD = 4'b1111;
    localparam logic [3:0] CTRL_R1   = 4'b0001;
    localparam logic [3:0] CTRL_L1   = 4'b0100;
    localparam logic [3:0] CTRL_R2   = 4'b0011;
    localparam logic [3:0] CTRL_L2   = 4'b0110;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SLOW_L,
        ST_FAST_L,
        ST_SLOW_R,
        ST_FAST_R
    } plate_state_t;

    typedef enum logic [1:0] {
        REQ_NONE,
        REQ_L,
        REQ_R
    } plate_req_t;

    // Index of the lowest set bit; 0 when no bit is set (callers treat an
    // empty bitmap separately).
    function automatic logic [3:0] lowest_set_bit(input logic [PLATE_W-1:0] bits);
        logic [3:0] idx;
        logic       found;
        idx   = 4'd0;
        found = 1'b0;
        for (int i = 0; i < PLATE_W; i++) begin
            if (!found && bits[i]) begin
                idx   = i[3:0];
                found = 1'b1;
            end
        end
        return idx;
    endfunction

endpackage

// File: rtl/plate_tick_gen.sv
// Game-tick generator: a free-running 0..TICK_DIV-1 counter that is cleared
// and silenced while paused, so the first tick after release is a full
// period away.
module plate_tick_gen #(
    parameter int TICK_DIV = 50000
) (
    input  logic clock,
    input  logic reset,
    input  logic i_pause,
    output logic o_tick
);

    localparam int              CNT_W    = $clog2(TICK_DIV);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TICK_DIV - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    logic [CNT_W-1:0] r_count;
    logic             w_at_last;

    assign w_at_last = (r_count == CNT_LAST);
    assign o_tick    = w_at_last && !i_pause;

    // Period counter: held at zero while paused, wraps after the last count.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_count <= '0;
        end else if (i_pause || w_at_last) begin
            r_count <= '0;
        end else begin
            r_count <= r_count + CNT_ONE;
        end
    end

endmodule

// File: rtl/plate_ctrl.sv
// Plate controller: turns synchronized buttons or ball-tracking demo mode
// into one-cycle plate control pulses at the game-tick rate, with
// hold-to-accelerate and blocking at the playfield edges.
module plate_ctrl
    import plate_pkg::*;
#(
    parameter int TICK_DIV    = 50000,
    parameter int ACCEL_TICKS = 4
) (
    input  logic               clock,
    input  logic               reset,
    input  logic               btn_left,
    input  logic               btn_right,
    input  logic               auto_en,
    input  logic [3:0]         ball_col,
    input  logic               pause,
    input  logic [PLATE_W-1:0] plate_pos,
    output logic [3:0]         control,
    output logic               moving,
    output logic               fast
);

    localparam int                HOLD_W    = $clog2(ACCEL_TICKS + 1);
    localparam logic [HOLD_W-1:0] HOLD_MAX  = HOLD_W'(ACCEL_TICKS);
    localparam logic [HOLD_W-1:0] HOLD_ONE  = HOLD_W'(1);
    localparam logic [HOLD_W:0]   ACCEL_CMP = (HOLD_W + 1)'(ACCEL_TICKS);

    // Code issued for one cycle after a tick lands the FSM in a given state.
    function automatic logic [3:0] state_code(input plate_state_t s);
        case (s)
            ST_SLOW_L: return CTRL_L1;
            ST_FAST_L: return CTRL_L2;
            ST_SLOW_R: return CTRL_R1;
            ST_FAST_R: return CTRL_R2;
            default:   return CTRL_HOLD;
        endcase
    endfunction

    logic              r_left_s1, r_left_s2;
    logic              r_right_s1, r_right_s2;
    logic              w_tick;
    logic [3:0]        w_low;
    logic [4:0]        w_low_p1, w_low_p2, w_ball;
    plate_req_t        w_req;
    logic              w_req_auto;
    plate_state_t      r_state, w_state_nxt;
    logic [HOLD_W-1:0] r_hold, w_hold_nxt, w_hold_inc;
    logic              w_accel_reach;
    logic [3:0]        r_control;
    logic              r_moving, r_fast;

    plate_tick_gen #(
        .TICK_DIV(TICK_DIV)
    ) u_tick (
        .clock   (clock),
        .reset   (reset),
        .i_pause (pause),
        .o_tick  (w_tick)
    );

    // Two-flop synchronizers for the asynchronous buttons.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_left_s1  <= 1'b0;
            r_left_s2  <= 1'b0;
            r_right_s1 <= 1'b0;
            r_right_s2 <= 1'b0;
        end else begin
            r_left_s1  <= btn_left;
            r_left_s2  <= r_left_s1;
            r_right_s1 <= btn_right;
            r_right_s2 <= r_right_s1;
        end
    end

    // Plate occupies w_low..w_low+3; auto mode keeps the ball over the middle pair.
    assign w_low    = lowest_set_bit(plate_pos);
    assign w_low_p1 = {1'b0, w_low} + 5'd1;
    assign w_low_p2 = {1'b0, w_low} + 5'd2;
    assign w_ball   = {1'b0, ball_col};

    // Request arbitration: manual beats auto, both buttons cancel, edges block.
    always_comb begin
        w_req      = REQ_NONE;
        w_req_auto = 1'b0;
        if (plate_pos == '0) begin
            w_req = REQ_NONE;
        end else if (r_left_s2 && !r_right_s2) begin
            w_req = REQ_L;
        end else if (r_right_s2 && !r_left_s2) begin
            w_req = REQ_R;
        end else if (!r_left_s2 && !r_right_s2 && auto_en) begin
            w_req_auto = 1'b1;
            if (w_ball > w_low_p2) begin
                w_req = REQ_L;
            end else if (w_ball < w_low_p1) begin
                w_req = REQ_R;
            end
        end
        if (w_req == REQ_L && plate_pos[PLATE_W-1]) begin
            w_req = REQ_NONE;
        end
        if (w_req == REQ_R && plate_pos[0]) begin
            w_req = REQ_NONE;
        end
    end

    assign w_hold_inc    = (r_hold >= HOLD_MAX) ? HOLD_MAX : (r_hold + HOLD_ONE);
    assign w_accel_reach = (({1'b0, r_hold} + (HOLD_W + 1)'(1)) >= ACCEL_CMP);

    // Next-state logic; nothing moves except on a tick.
    always_comb begin
        w_state_nxt = r_state;
        w_hold_nxt  = r_hold;
        if (w_tick) begin
            case (w_req)
                REQ_L: begin
                    if (r_state == ST_SLOW_L || r_state == ST_FAST_L) begin
                        w_hold_nxt = w_hold_inc;
                        if (w_req_auto) begin
                            w_state_nxt = ST_SLOW_L;
                        end else if (r_state == ST_FAST_L || w_accel_reach) begin
                            w_state_nxt = ST_FAST_L;
                        end else begin
                            w_state_nxt = ST_SLOW_L;
                        end
                    end else begin
                        w_state_nxt = ST_SLOW_L;
                        w_hold_nxt  = HOLD_ONE;
                    end
                end
                REQ_R: begin
                    if (r_state == ST_SLOW_R || r_state == ST_FAST_R) begin
                        w_hold_nxt = w_hold_inc;
                        if (w_req_auto) begin
                            w_state_nxt = ST_SLOW_R;
                        end else if (r_state == ST_FAST_R || w_accel_reach) begin
                            w_state_nxt = ST_FAST_R;
                        end else begin
                            w_state_nxt = ST_SLOW_R;
                        end
                    end else begin
                        w_state_nxt = ST_SLOW_R;
                        w_hold_nxt  = HOLD_ONE;
                    end
                end
                default: begin
                    w_state_nxt = ST_IDLE;
                    w_hold_nxt  = '0;
                end
            endcase
        end
    end

    // FSM state and hold-count registers.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_state <= ST_IDLE;
            r_hold  <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_hold  <= w_hold_nxt;
        end
    end

    // Registered outputs: one-cycle code pulse after each tick, state decodes.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_control <= CTRL_HOLD;
            r_moving  <= 1'b0;
            r_fast    <= 1'b0;
        end else begin
            r_control <= w_tick ? state_code(w_state_nxt) : CTRL_HOLD;
            r_moving  <= (w_state_nxt != ST_IDLE);
            r_fast    <= (w_state_nxt == ST_FAST_L) || (w_state_nxt == ST_FAST_R);
        end
    end

    assign control = r_control;
    assign moving  = r_moving;
    assign fast    = r_fast;

endmodule

// File: tb/tb_plate_ctrl.sv
// Scoreboard bench for plate_ctrl with a short tick period.
module tb_plate_ctrl;

    localparam int TD = 4;
    localparam int AT = 4;

    localparam logic [3:0] HOLD = 4'b1111;
    localparam logic [3:0] R1   = 4'b0001;
    localparam logic [3:0] L1   = 4'b0100;
    localparam logic [3:0] R2   = 4'b0011;
    localparam logic [3:0] L2   = 4'b0110;

    typedef struct packed {
        logic [3:0]  code;
        logic        fast;
        logic        moving;
        logic [31:0] cyc;
    } pulse_t;

    logic        clock = 1'b0;
    logic        reset = 1'b0;
    logic        btn_left = 1'b0;
    logic        btn_right = 1'b0;
    logic        auto_en = 1'b0;
    logic [3:0]  ball_col = 4'd0;
    logic        pause = 1'b0;
    logic [15:0] plate_pos = 16'h0000;
    logic [3:0]  control;
    logic        moving;
    logic        fast;

    pulse_t exp_q[$];
    pulse_t obs_q[$];
    int     n_checks = 0;
    int     n_fail = 0;
    int     cyc = 0;

    plate_ctrl #(
        .TICK_DIV   (TD),
        .ACCEL_TICKS(AT)
    ) dut (
        .clock     (clock),
        .reset     (reset),
        .btn_left  (btn_left),
        .btn_right (btn_right),
        .auto_en   (auto_en),
        .ball_col  (ball_col),
        .pause     (pause),
        .plate_pos (plate_pos),
        .control   (control),
        .moving    (moving),
        .fast      (fast)
    );

    always #5 clock = ~clock;

    // Advance n cycles, recording every non-HOLD control cycle as a pulse.
    task automatic step(input int n);
        pulse_t p;
        for (int i = 0; i < n; i++) begin
            @(negedge clock);
            cyc++;
            if (control !== HOLD) begin
                p = '{code: control, fast: fast, moving: moving, cyc: 32'(cyc)};
                obs_q.push_back(p);
            end
        end
    endtask

    task automatic expect_pulse(input logic [3:0] code, input logic f, input int at);
        pulse_t p;
        p = '{code: code, fast: f, moving: 1'b1, cyc: 32'(at)};
        exp_q.push_back(p);
    endtask

    task automatic set_inputs(input logic l, input logic r, input logic a,
                              input logic [3:0] col, input logic p, input logic [15:0] pos);
        btn_left  = l;
        btn_right = r;
        auto_en   = a;
        ball_col  = col;
        pause     = p;
        plate_pos = pos;
    endtask

    // Pulse reset for one cycle; cycle numbering restarts at release.
    task automatic restart();
        @(negedge clock);
        reset = 1'b0;
        @(negedge clock);
        reset = 1'b1;
        cyc = 0;
    endtask

    task automatic test_reset();
        pulse_t e, o;
        repeat (2) @(negedge clock);
        n_checks++;
        if (control !== HOLD) begin n_fail++; $display("FAIL reset_control: got %b, need %b", control, HOLD); end
        n_checks++;
        if (moving !== 1'b0) begin n_fail++; $display("FAIL reset_moving: got %b, need 0", moving); end
        n_checks++;
        if (fast !== 1'b0) begin n_fail++; $display("FAIL reset_fast: got %b, need 0", fast); end
        set_inputs(1'b1, 1'b0, 1'b0, 4'd0, 1'b0, 16'h03C0);
        reset = 1'b1;
        cyc = 0;
        expect_pulse(L1, 1'b0, TD);
        step(TD);
        // control is mid-pulse here; assert reset between edges
        #2 reset = 1'b0;
        #1;
        n_checks++;
        if (control !== HOLD) begin n_fail++; $display("FAIL async_reset_control: got %b, need %b", control, HOLD); end
        n_checks++;
        if (moving !== 1'b0) begin n_fail++; $display("FAIL async_reset_moving: got %b, need 0", moving); end
        n_checks++;
        if (fast !== 1'b0) begin n_fail++; $display("FAIL async_reset_fast: got %b, need 0", fast); end
        @(negedge clock);
        reset = 1'b1;
        cyc = 0;
        expect_pulse(L1, 1'b0, TD);
        step(2 * TD - 1);
        exp_q.pop_back();
        expect_pulse(L1, 1'b0, TD);
        expect_pulse(L1, 1'b0, 2 * TD - 1 + 1);
        step(1);
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            n_checks++;
            if (obs_q.size() == 0) begin
                n_fail++;
                $display("FAIL reset_seq: no pulse, need code=%b at cycle %0d", e.code, e.cyc);
            end else begin
                o = obs_q.pop_front();
                if (o !== e) begin
                    n_fail++;
                    $display("FAIL reset_seq: got code=%b fast=%b moving=%b cyc=%0d, need code=%b fast=%b moving=%b cyc=%0d",
                             o.code, o.fast, o.moving, o.cyc, e.code, e.fast, e.moving, e.cyc);
                end
            end
        end
        n_checks++;
        if (obs_q.size() != 0) begin
            n_fail++;
            $display("FAIL reset_seq: %0d extra pulse(s), first code=%b cyc=%0d", obs_q.size(), obs_q[0].code, obs_q[0].cyc);
            obs_q.delete();
        end
    endtask

    task automatic test_accel_left();
        pulse_t e, o;
        set_inputs(1'b1, 1'b0, 1'b0, 4'd0, 1'b0, 16'h03C0);
        restart();
        for (int k = 1; k <= 5; k++) begin
            if (k < AT) expect_pulse(L1, 1'b0, k * TD);
            else        expect_pulse(L2, 1'b1, k * TD);
        end
        step(5 * TD);
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            n_checks++;
            if (obs_q.size() == 0) begin
                n_fail++;
                $display("FAIL accel_left: no pulse, need code=%b at cycle %0d", e.code, e.cyc);
            end else begin
                o = obs_q.pop_front();
                if (o !== e) begin
                    n_fail++;
                    $display("FAIL accel_left: got code=%b fast=%b moving=%b cyc=%0d, need code=%b fast=%b moving=%b cyc=%0d",
                             o.code, o.fast, o.moving, o.cyc, e.code, e.fast, e.moving, e.cyc);
                end
            end
        end
        n_checks++;
        if (obs_q.size() != 0) begin
            n_fail++;
            $display("FAIL accel_left: %0d extra pulse(s), first code=%b cyc=%0d", obs_q.size(), obs_q[0].code, obs_q[0].cyc);
            obs_q.delete();
        end
    endtask

    task automatic test_edge_block();
        pulse_t e, o;
        set_inputs(1'b1, 1'b0, 1'b0, 4'd0, 1'b0, 16'hF000);
        restart();
        step(3 * TD);
        n_checks++;
        if (moving !== 1'b0) begin n_fail++; $display("FAIL edge_left_moving: got %b, need 0", moving); end
        btn_left  = 1'b0;
        btn_right = 1'b1;
        expect_pulse(R1, 1'b0, 4 * TD);
        step(TD);
        n_checks++;
        if (moving !== 1'b1) begin n_fail++; $display("FAIL edge_right_moving: got %b, need 1", moving); end
        plate_pos = 16'h000F;
        step(2 * TD);
        n_checks++;
        if (moving !== 1'b0) begin n_fail++; $display("FAIL edge_right_block_moving: got %b, need 0", moving); end
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            n_checks++;
            if (obs_q.size() == 0) begin
                n_fail++;
                $display("FAIL edge_block: no pulse, need code=%b at cycle %0d", e.code, e.cyc);
            end else begin
                o = obs_q.pop_front();
                if (o !== e) begin
                    n_fail++;
                    $display("FAIL edge_block: got code=%b fast=%b moving=%b cyc=%0d, need code=%b fast=%b moving=%b cyc=%0d",
                             o.code, o.fast, o.moving, o.cyc, e.code, e.fast, e.moving, e.cyc);
                end
            end
        end
        n_checks++;
        if (obs_q.size() != 0) begin
            n_fail++;
            $display("FAIL edge_block: %0d extra pulse(s), first code=%b cyc=%0d", obs_q.size(), obs_q[0].code, obs_q[0].cyc);
            obs_q.delete();
        end
    endtask

    task automatic test_reverse();
        pulse_t e, o;
        set_inputs(1'b1, 1'b0, 1'b0, 4'd0, 1'b0, 16'h03C0);
        restart();
        for (int k = 1; k <= 5; k++) begin
            if (k < AT) expect_pulse(L1, 1'b0, k * TD);
            else        expect_pulse(L2, 1'b1, k * TD);
        end
        step(5 * TD);
        btn_left  = 1'b0;
        btn_right = 1'b1;
        for (int k = 1; k <= AT; k++) begin
            if (k < AT) expect_pulse(R1, 1'b0, (5 + k) * TD);
            else        expect_pulse(R2, 1'b1, (5 + k) * TD);
        end
        step(AT * TD);
        btn_left = 1'b1;
        step(2 * TD);
        n_checks++;
        if (moving !== 1'b0) begin n_fail++; $display("FAIL both_buttons_moving: got %b, need 0", moving); end
        n_checks++;
        if (fast !== 1'b0) begin n_fail++; $display("FAIL both_buttons_fast: got %b, need 0", fast); end
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            n_checks++;
            if (obs_q.size() == 0) begin
                n_fail++;
                $display("FAIL reverse: no pulse, need code=%b at cycle %0d", e.code, e.cyc);
            end else begin
                o = obs_q.pop_front();
                if (o !== e) begin
                    n_fail++;
                    $display("FAIL reverse: got code=%b fast=%b moving=%b cyc=%0d, need code=%b fast=%b moving=%b cyc=%0d",
                             o.code, o.fast, o.moving, o.cyc, e.code, e.fast, e.moving, e.cyc);
                end
            end
        end
        n_checks++;
        if (obs_q.size() != 0) begin
            n_fail++;
            $display("FAIL reverse: %0d extra pulse(s), first code=%b cyc=%0d", obs_q.size(), obs_q[0].code, obs_q[0].cyc);
            obs_q.delete();
        end
    endtask

    task automatic test_auto();
        pulse_t e, o;
        set_inputs(1'b0, 1'b0, 1'b1, 4'd12, 1'b0, 16'h03C0);
        restart();
        for (int k = 1; k <= 6; k++) expect_pulse(L1, 1'b0, k * TD);
        step(6 * TD);
        ball_col = 4'd7;
        step(TD);
        n_checks++;
        if (moving !== 1'b0) begin n_fail++; $display("FAIL auto_col7_moving: got %b, need 0", moving); end
        ball_col = 4'd8;
        step(TD);
        n_checks++;
        if (moving !== 1'b0) begin n_fail++; $display("FAIL auto_col8_moving: got %b, need 0", moving); end
        ball_col = 4'd2;
        expect_pulse(R1, 1'b0, 9 * TD);
        step(TD);
        ball_col  = 4'd12;
        btn_right = 1'b1;
        expect_pulse(R1, 1'b0, 10 * TD);
        step(TD);
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            n_checks++;
            if (obs_q.size() == 0) begin
                n_fail++;
                $display("FAIL auto: no pulse, need code=%b at cycle %0d", e.code, e.cyc);
            end else begin
                o = obs_q.pop_front();
                if (o !== e) begin
                    n_fail++;
                    $display("FAIL auto: got code=%b fast=%b moving=%b cyc=%0d, need code=%b fast=%b moving=%b cyc=%0d",
                             o.code, o.fast, o.moving, o.cyc, e.code, e.fast, e.moving, e.cyc);
                end
            end
        end
        n_checks++;
        if (obs_q.size() != 0) begin
            n_fail++;
            $display("FAIL auto: %0d extra pulse(s), first code=%b cyc=%0d", obs_q.size(), obs_q[0].code, obs_q[0].cyc);
            obs_q.delete();
        end
    endtask

    task automatic test_pause();
        pulse_t e, o;
        set_inputs(1'b1, 1'b0, 1'b0, 4'd0, 1'b0, 16'h03C0);
        restart();
        for (int k = 1; k <= AT; k++) begin
            if (k < AT) expect_pulse(L1, 1'b0, k * TD);
            else        expect_pulse(L2, 1'b1, k * TD);
        end
        step(AT * TD);
        pause = 1'b1;
        step(3 * TD);
        n_checks++;
        if (fast !== 1'b1) begin n_fail++; $display("FAIL pause_fast: got %b, need 1", fast); end
        n_checks++;
        if (moving !== 1'b1) begin n_fail++; $display("FAIL pause_moving: got %b, need 1", moving); end
        pause = 1'b0;
        expect_pulse(L2, 1'b1, (AT + 3) * TD + TD);
        step(TD);
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            n_checks++;
            if (obs_q.size() == 0) begin
                n_fail++;
                $display("FAIL pause: no pulse, need code=%b at cycle %0d", e.code, e.cyc);
            end else begin
                o = obs_q.pop_front();
                if (o !== e) begin
                    n_fail++;
                    $display("FAIL pause: got code=%b fast=%b moving=%b cyc=%0d, need code=%b fast=%b moving=%b cyc=%0d",
                             o.code, o.fast, o.moving, o.cyc, e.code, e.fast, e.moving, e.cyc);
                end
            end
        end
        n_checks++;
        if (obs_q.size() != 0) begin
            n_fail++;
            $display("FAIL pause: %0d extra pulse(s), first code=%b cyc=%0d", obs_q.size(), obs_q[0].code, obs_q[0].cyc);
            obs_q.delete();
        end
    endtask

    initial begin
        test_reset();
        test_accel_left();
        test_edge_block();
        test_reverse();
        test_auto();
        test_pause();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
